// File: rtl/multicycle_ctrl.sv
// Multi-cycle fetch/decode/execute/memory/write-back controller for the 8-bit datapath.
// Optional macro RETIRE_CNT_EN adds the 16-bit retired-instruction counter.
module multicycle_ctrl #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [7:0]  imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        alu_zero,
    output logic [7:0]  adr_1,
    output logic [7:0]  adr_2,
    output logic [7:0]  adr_3,
    output logic [7:0]  opcode_out,
    output logic        rf_we,
    output logic        rf_wsel,
    output logic [7:0]  pc,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_NOP, C_ALU, C_LOAD, C_STORE, C_JMP, C_BEQ, C_HALT, C_ILL
    } op_class_t;

    state_t    state, state_nx;
    op_class_t op_class;
    logic [31:0] ir;
    logic [7:0]  pc_nx;
    logic        armed;
    logic        ir_load;
    logic        ill_set;

    // The instruction register is the single source of the decoded fields.
    assign opcode_out = ir[31:24];
    assign adr_1      = ir[23:16];
    assign adr_2      = ir[15:8];
    assign adr_3      = ir[7:0];
    assign imem_addr  = pc;

    always_comb begin
        if (ir[31:24] == 8'h00)       op_class = C_NOP;
        else if (ir[31:24] <= 8'h0F)  op_class = C_ALU;
        else if (ir[31:24] == 8'h10)  op_class = C_LOAD;
        else if (ir[31:24] == 8'h11)  op_class = C_STORE;
        else if (ir[31:24] == 8'h20)  op_class = C_JMP;
        else if (ir[31:24] == 8'h21)  op_class = C_BEQ;
        else if (ir[31:24] == 8'hFF)  op_class = C_HALT;
        else                          op_class = C_ILL;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_nx = state;
        pc_nx    = pc;
        ir_load  = 1'b0;
        ill_set  = 1'b0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        rf_wsel  = 1'b0;
        halted   = 1'b0;
        unique case (state)
            S_FETCH: begin
                // armed holds the request off for the first cycle out of reset.
                imem_req = armed;
                if (armed && imem_ack) begin
                    ir_load  = 1'b1;
                    state_nx = S_DECODE;
                end
            end
            S_DECODE: begin
                ill_set  = (op_class == C_ILL);
                state_nx = S_EXEC;
            end
            S_EXEC: begin
                state_nx = S_FETCH;
                case (op_class)
                    C_ALU:           state_nx = S_WB;
                    C_LOAD, C_STORE: state_nx = S_MEM;
                    C_JMP:           pc_nx = ir[7:0];
                    C_BEQ:           pc_nx = alu_zero ? ir[7:0] : pc + 8'd1;
                    C_HALT:          state_nx = S_HALT;
                    default:         pc_nx = pc + 8'd1;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op_class == C_STORE);
                if (dmem_ack) begin
                    if (op_class == C_STORE) begin
                        pc_nx    = pc + 8'd1;
                        state_nx = S_FETCH;
                    end else begin
                        state_nx = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_wsel  = (op_class == C_LOAD);
                pc_nx    = pc + 8'd1;
                state_nx = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: state_nx = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state   <= S_FETCH;
            armed   <= 1'b0;
            pc      <= RESET_PC;
            ir      <= 32'h0;
            illegal <= 1'b0;
        end else begin
            state <= state_nx;
            armed <= 1'b1;
            pc    <= pc_nx;
            if (ir_load) ir <= imem_rdata;
            if (ill_set) illegal <= 1'b1;
        end
    end

`ifdef RETIRE_CNT_EN
    logic        retire;
    logic [15:0] retired_q;

    // An instruction retires when its last phase hands control back to FETCH or into HALT.
    assign retire = (state == S_EXEC || state == S_MEM || state == S_WB) &&
                    (state_nx == S_FETCH || state_nx == S_HALT);

    always_ff @(posedge clk) begin
        if (!rst)        retired_q <= 16'h0000;
        else if (retire) retired_q <= retired_q + 16'd1;
    end

    assign retired = retired_q;
`else
    assign retired = 16'h0000;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a per-instruction latency model expands a directed program
// into an expected per-cycle trace that drives the inputs and is compared every cycle.
module tb_multicycle_ctrl;

    localparam logic [7:0]  RESET_PC = 8'h00;
    localparam logic [31:0] JUNK     = 32'hA5A5_5A5A;
`ifdef RETIRE_CNT_EN
    localparam logic [15:0] RET_STEP = 16'd1;
`else
    localparam logic [15:0] RET_STEP = 16'd0;
`endif

    localparam int K_NOP = 0, K_ALU = 1, K_LOAD = 2, K_STORE = 3;
    localparam int K_JMP = 4, K_BEQ = 5, K_HALT = 6, K_ILL = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, alu_zero;
    logic [7:0]  imem_addr, adr_1, adr_2, adr_3, opcode_out, pc;
    logic [31:0] imem_rdata;
    logic        rf_we, rf_wsel, halted, illegal;
    logic [15:0] retired;

    always #5 clk = ~clk;

    multicycle_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .alu_zero(alu_zero),
        .adr_1(adr_1), .adr_2(adr_2), .adr_3(adr_3), .opcode_out(opcode_out),
        .rf_we(rf_we), .rf_wsel(rf_wsel), .pc(pc), .halted(halted),
        .illegal(illegal), .retired(retired)
    );

    // One cycle: inputs to drive, and the outputs required during that cycle.
    typedef struct packed {
        logic        rst, ia;
        logic [31:0] ird;
        logic        da, az;
        logic        ireq;
        logic [7:0]  iaddr;
        logic        dreq, dwe, rfwe, rfwsel, halted;
        logic [7:0]  pc, a1, a2, a3, op;
        logic        ill;
        logic [15:0] ret;
    } cyc_t;

    cyc_t        trace[$];
    logic [31:0] imem [256];
    logic [7:0]  m_pc, m_a1, m_a2, m_a3, m_op;
    logic        m_ill;
    logic [15:0] m_ret;

    int n_checks = 0;
    int n_errors = 0;
    int cur      = 0;
    bit valid    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (record %0d, t=%0t): got %h expected %h", name, cur, $time, act, exp);
        end
    endtask

    function automatic int kind(input logic [7:0] op);
        if (op == 8'h00)                     return K_NOP;
        if (op >= 8'h01 && op <= 8'h0F)      return K_ALU;
        if (op == 8'h10)                     return K_LOAD;
        if (op == 8'h11)                     return K_STORE;
        if (op == 8'h20)                     return K_JMP;
        if (op == 8'h21)                     return K_BEQ;
        if (op == 8'hFF)                     return K_HALT;
        return K_ILL;
    endfunction

    // Baseline cycle: no strobes, architectural state as currently visible.
    function automatic cyc_t mk();
        cyc_t r;
        r       = '0;
        r.rst   = 1'b1;
        r.ird   = JUNK;
        r.az    = 1'b1;
        r.iaddr = m_pc;
        r.pc    = m_pc;
        r.a1    = m_a1;
        r.a2    = m_a2;
        r.a3    = m_a3;
        r.op    = m_op;
        r.ill   = m_ill;
        r.ret   = m_ret;
        return r;
    endfunction

    task automatic gen_reset();
        cyc_t r;
        if (trace.size() > 0) trace[trace.size()-1].rst = 1'b0;
        m_pc = RESET_PC; m_a1 = 8'h0; m_a2 = 8'h0; m_a3 = 8'h0; m_op = 8'h0;
        m_ill = 1'b0; m_ret = 16'h0;
        r = mk(); r.rst = 1'b0; r.ia = 1'b1; r.da = 1'b1;
        trace.push_back(r);
        // First cycle out of reset: no request yet, so this HALT word must be ignored.
        r = mk(); r.ia = 1'b1; r.ird = 32'hFF00_0000; r.da = 1'b1;
        trace.push_back(r);
    endtask

    task automatic gen_instr(input int iwait, input int dwait, input logic az, input int abort_at);
        cyc_t        r;
        logic [31:0] w;
        int          k;
        w = imem[m_pc];
        k = kind(w[31:24]);
        for (int i = 0; i <= iwait; i++) begin
            r = mk(); r.ireq = 1'b1; r.da = 1'b1;
            if (i == iwait) begin r.ia = 1'b1; r.ird = w; end
            trace.push_back(r);
        end
        m_op = w[31:24]; m_a1 = w[23:16]; m_a2 = w[15:8]; m_a3 = w[7:0];
        trace.push_back(mk());
        if (k == K_ILL) m_ill = 1'b1;
        r = mk(); r.az = az;
        trace.push_back(r);
        if (k == K_LOAD || k == K_STORE) begin
            for (int i = 0; i <= dwait; i++) begin
                r = mk(); r.dreq = 1'b1; r.dwe = (k == K_STORE); r.ia = 1'b1;
                if (i == dwait) r.da = 1'b1;
                if (i == abort_at) begin
                    r.rst = 1'b0; r.da = 1'b0;
                    trace.push_back(r);
                    return;
                end
                trace.push_back(r);
            end
        end
        if (k == K_ALU || k == K_LOAD) begin
            r = mk(); r.rfwe = 1'b1; r.rfwsel = (k == K_LOAD);
            trace.push_back(r);
        end
        case (k)
            K_JMP:   m_pc = w[7:0];
            K_BEQ:   m_pc = az ? w[7:0] : m_pc + 8'd1;
            K_HALT:  ;
            default: m_pc = m_pc + 8'd1;
        endcase
        m_ret = m_ret + RET_STEP;
    endtask

    task automatic gen_halt(input int n);
        cyc_t r;
        for (int i = 0; i < n; i++) begin
            r = mk(); r.halted = 1'b1; r.ia = 1'b1; r.da = 1'b1; r.ird = 32'h0300_0000;
            trace.push_back(r);
        end
    endtask

    task automatic build();
        int len0;
        for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0000;
        imem[8'h00] = 32'h0301_0205;   // ALU
        imem[8'h01] = 32'h1004_0007;   // LOAD
        imem[8'h02] = 32'h1100_0700;   // STORE
        imem[8'h03] = 32'h2101_0240;   // BEQ -> 0x40
        imem[8'h04] = 32'hFF00_0000;   // HALT
        imem[8'h40] = 32'h2100_0080;   // BEQ -> 0x80
        imem[8'h41] = 32'h0F0A_0B0C;   // ALU
        imem[8'h42] = 32'h7E11_2233;   // illegal
        imem[8'h43] = 32'h0000_0000;   // NOP
        imem[8'h44] = 32'h2000_00FE;   // JMP -> 0xFE
        imem[8'hFE] = 32'h0101_0101;   // ALU
        imem[8'hFF] = 32'h0000_0000;   // NOP, wraps to 0x00

        gen_reset();
        len0 = trace.size(); gen_instr(0, 0, 1'b1, -1);
        check("pin_alu_len", trace.size() - len0, 4);
        len0 = trace.size(); gen_instr(0, 3, 1'b1, -1);
        check("pin_load_len", trace.size() - len0, 8);
        len0 = trace.size(); gen_instr(2, 1, 1'b1, -1);
        check("pin_store_len", trace.size() - len0, 7);
        gen_instr(0, 0, 1'b1, -1);
        check("pin_beq_taken", m_pc, 8'h40);
        len0 = trace.size(); gen_instr(0, 0, 1'b0, -1);
        check("pin_beq_fall", m_pc, 8'h41);
        check("pin_beq_len", trace.size() - len0, 3);
        gen_instr(1, 0, 1'b1, -1);
        gen_instr(0, 0, 1'b1, -1);
        check("pin_illegal", m_ill, 1'b1);
        gen_instr(0, 0, 1'b1, -1);
        gen_instr(0, 0, 1'b1, -1);
        gen_instr(0, 0, 1'b1, -1);
        gen_instr(0, 0, 1'b1, -1);
        check("pin_wrap", m_pc, 8'h00);
        gen_instr(0, 0, 1'b1, -1);
        gen_instr(0, 3, 1'b1, 1);      // reset lands mid-MEM of the LOAD
        gen_reset();
        gen_instr(0, 0, 1'b1, -1);
        len0 = trace.size(); gen_instr(0, 0, 1'b1, -1);
        check("pin_load_fast", trace.size() - len0, 5);
        gen_instr(0, 0, 1'b1, -1);
        gen_instr(0, 0, 1'b0, -1);
        gen_instr(0, 0, 1'b1, -1);
        check("pin_halt_pc", m_pc, 8'h04);
        check("pin_retired", m_ret, 16'd5 * RET_STEP);
        gen_halt(20);
        gen_reset();
        gen_instr(0, 0, 1'b1, -1);
    endtask

    always @(negedge clk) begin
        if (valid) begin
            cyc_t e;
            e = trace[cur];
            check("bus", {imem_req, imem_addr, dmem_req, dmem_we}, {e.ireq, e.iaddr, e.dreq, e.dwe});
            check("rf_halt", {rf_we, rf_wsel, halted}, {e.rfwe, e.rfwsel, e.halted});
            check("pc", pc, e.pc);
            check("decode", {adr_1, adr_2, adr_3, opcode_out}, {e.a1, e.a2, e.a3, e.op});
            check("status", {illegal, retired}, {e.ill, e.ret});
        end
    end

    initial begin
        rst        = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = JUNK;
        dmem_ack   = 1'b0;
        alu_zero   = 1'b0;
        build();
        @(posedge clk);
        for (int i = 0; i < trace.size(); i++) begin
            #1;
            rst        = trace[i].rst;
            imem_ack   = trace[i].ia;
            imem_rdata = trace[i].ird;
            dmem_ack   = trace[i].da;
            alu_zero   = trace[i].az;
            cur        = i;
            valid      = 1'b1;
            @(posedge clk);
        end
        valid = 1'b0;
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the 8-bit processor datapath. It fetches 32-bit instructions over a request/acknowledge instruction port and decodes each into opcode and three 8-bit register-file addresses. It then sequences execute, data-memory and write-back phases through a fixed state machine. It sits between instruction/data memory and the register file/ALU, and drives the ADR_1/ADR_2/ADR_3 and opcode signals the datapath consumes.

## Interface
Parameters:
- RESET_PC, 8'h00, program counter value loaded on reset.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  8  fetch address; equals pc.
- imem_ack  in  1  instruction valid on imem_rdata this cycle.
- imem_rdata  in  32  instruction word: [31:24] opcode, [23:16] A1, [15:8] A2, [7:0] A3.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req is high.
- dmem_ack  in  1  data access complete.
- alu_zero  in  1  ALU zero flag from the datapath.
- adr_1, adr_2, adr_3  out  8 each  register-file read/read/write addresses.
- opcode_out  out  8  latched opcode.
- rf_we  out  1  register-file write enable, one-cycle pulse.
- rf_wsel  out  1  write-back source: 0 = ALU, 1 = data memory.
- pc  out  8  current program counter.
- halted  out  1  high in HALT.
- illegal  out  1  sticky: an undefined opcode was decoded.
- retired  out  16  retired-instruction count.

## Operation
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH: imem_req=1. On imem_ack=1, latch imem_rdata into the instruction register, then go to DECODE. Otherwise hold.
- DECODE: drive adr_1/adr_2/adr_3/opcode_out from the instruction register. These stay stable until the next DECODE.
- Opcode classes:
  - 0x00 NOP.
  - 0x01–0x0F ALU, writes back.
  - 0x10 LOAD.
  - 0x11 STORE.
  - 0x20 JMP.
  - 0x21 BEQ.
  - 0xFF HALT.
  - Anything else is illegal: set illegal and execute as NOP.
- EXEC:
  - ALU → WB with rf_wsel=0.
  - LOAD/STORE → MEM.
  - JMP: pc ← A3, then FETCH.
  - BEQ: if alu_zero=1, pc ← A3; else pc ← pc+1; then FETCH.
  - NOP/illegal: pc ← pc+1, then FETCH.
  - HALT → HALT.
- MEM: dmem_req=1, dmem_we=1 for STORE. Hold until dmem_ack. Then:
  - LOAD → WB with rf_wsel=1.
  - STORE: pc ← pc+1, then FETCH.
- WB: rf_we=1 for exactly this cycle, pc ← pc+1, then FETCH.
- PC arithmetic is 8-bit modulo: 0xFF+1 = 0x00. Fetching across the wrap is legal.
- HALT is absorbing. Only reset leaves it. All requests stay low and pc is frozen.
- An instruction retires on leaving EXEC, MEM or WB toward FETCH or HALT. HALT itself counts. retired wraps 0xFFFF → 0x0000.

## Timing
- Reset (rst=0 at a rising edge):
  - state = FETCH, pc = RESET_PC.
  - adr_* = 0, opcode_out = 0, illegal = 0, retired = 0.
  - All strobes (imem_req, dmem_req, dmem_we, rf_we, rf_wsel, halted) = 0 after that edge. imem_req rises one cycle after rst deasserts.
- Reset mid-operation aborts immediately. Pending req drops at the same edge and the late ack is ignored.
- Requests are level signals. The controller never deasserts a request before its ack. An ack with no request is ignored.
- Latencies, counted in cycles with zero-wait acks (ack high in the first request cycle):
  - ALU and LOAD: 4 cycles (FETCH, DECODE, EXEC, WB). LOAD adds the MEM cycle, giving 5.
  - STORE: 4 cycles.
  - JMP, BEQ, NOP: 3 cycles.
  - Each wait cycle on an ack adds one cycle.
- pc updates on the edge that leaves EXEC, MEM or WB. imem_addr reflects the new pc in the following FETCH.
- rf_we is never high outside WB. dmem_req and imem_req are never high simultaneously.

## Configuration
- RETIRE_CNT_EN:
  - Defined: the 16-bit retired counter is implemented as above.
  - Undefined: the counter logic is removed and the retired port is tied to 16'h0000. All other behaviour is identical.

## Test plan
- Reset then ALU instr 0x03_01_02_05, imem_ack immediate:
  - DECODE shows adr_1=0x01, adr_2=0x02, adr_3=0x05, opcode_out=0x03.
  - rf_we pulses once on cycle 4 with rf_wsel=0; pc 0x00→0x01.
- LOAD with dmem_ack delayed 3 cycles:
  - dmem_req high 4 cycles, dmem_we=0, then rf_we with rf_wsel=1.
  - retired increments by 1.
- BEQ A3=0x40: with alu_zero=1, next imem_addr=0x40. With alu_zero=0, next imem_addr=pc+1. rf_we never asserts.
- pc=0xFF executing NOP → next imem_addr=0x00. Opcode 0x7E → illegal=1, stays 1 through later legal instructions, pc advances.
- HALT: halted=1, no requests for 20 cycles, retired frozen. Assert rst=0 mid-MEM on a later run: dmem_req low after that edge, pc=RESET_PC.
- Build without RETIRE_CNT_EN: same program gives identical bus and rf_we traces, with retired=0 throughout.
